// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter in front of a single RAM
// with a done handshake, alignment fault detection and a WAIT-state timeout.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_mas,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [1:0]  ram_mas,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ram_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_grant_d;
    logic          r_last_d;
    logic          r_err;
    logic          r_rw;
    logic [1:0]    r_mas;
    logic [7:0]    r_addr;
    logic [31:0]   r_din;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;
    logic [CW-1:0] r_cnt;

    logic          w_any_req;
    logic          w_grant_d;
    logic [1:0]    w_sel_mas;
    logic [7:0]    w_sel_addr;
    logic          w_fault;
    logic          w_done_ok;
    logic          w_timeout;

    // Data wins a tie unless it was the last one served; fetches are always word reads.
    always_comb begin
        w_any_req  = if_req | d_req;
        w_grant_d  = d_req & (~if_req | ~r_last_d);
        w_sel_mas  = w_grant_d ? d_mas : 2'b10;
        w_sel_addr = w_grant_d ? d_addr : if_addr;
        w_fault    = (w_sel_mas == 2'b11) ||
                     ((w_sel_mas == 2'b01) && w_sel_addr[0]) ||
                     ((w_sel_mas == 2'b10) && (w_sel_addr[1:0] != 2'b00));
        w_done_ok  = (r_cnt >= WAIT_LAST) && ram_done;
        w_timeout  = (r_cnt == TO_LAST) && !ram_done;
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block, not its sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_next = w_fault ? S_RESP : S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (w_done_ok || w_timeout) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ram_enable = (r_state == S_ISSUE) || (r_state == S_WAIT);
        ram_rw     = r_rw;
        ram_mas    = r_mas;
        ram_addr   = r_addr;
        ram_din    = r_din;
        if_ack     = (r_state == S_RESP) && !r_grant_d;
        if_err     = (r_state == S_RESP) && !r_grant_d && r_err;
        d_ack      = (r_state == S_RESP) && r_grant_d;
        d_err      = (r_state == S_RESP) && r_grant_d && r_err;
        if_rdata   = r_if_rdata;
        d_rdata    = r_d_rdata;
    end

    // NOTE: every register here is state, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grant_d  <= 1'b0;
            r_last_d   <= 1'b0;
            r_err      <= 1'b0;
            r_rw       <= 1'b1;
            r_mas      <= 2'b00;
            r_addr     <= 8'h00;
            r_din      <= 32'h0;
            r_cnt      <= '0;
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_d <= w_grant_d;
                        r_last_d  <= w_grant_d;
                        r_err     <= w_fault;
                        r_rw      <= w_grant_d ? d_rw : 1'b1;
                        r_mas     <= w_sel_mas;
                        r_addr    <= w_sel_addr;
                        r_din     <= w_grant_d ? d_wdata : 32'h0;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (w_done_ok) begin
                        if (r_rw && r_grant_d)  r_d_rdata  <= ram_dout;
                        if (r_rw && !r_grant_d) r_if_rdata <= ram_dout;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a behavioural RAM plus a transaction-level
// reference model predict every ack/err, read data, latency and RAM-enable duration.
module tb_mem_arbiter;

    localparam int WC = 2;
    localparam int TO = 15;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req  = 1'b0;
    logic [7:0]  if_addr = 8'h00;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        d_req   = 1'b0;
    logic        d_rw    = 1'b1;
    logic [1:0]  d_mas   = 2'b00;
    logic [7:0]  d_addr  = 8'h00;
    logic [31:0] d_wdata = 32'h0;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        ram_enable;
    logic        ram_rw;
    logic [1:0]  ram_mas;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        ram_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.WAIT_CYCLES(WC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_mas(d_mas), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_mas(ram_mas), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_done(ram_done)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Behavioural big-endian RAM: done rises once enable has been high for done_delay cycles.
    logic [7:0] ram_mem [256];
    logic       mem_ready  = 1'b0;
    int         en_run     = 0;
    int         done_delay = 0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else if (ram_enable && ram_done && !ram_rw) begin
            case (ram_mas)
                2'b00: ram_mem[ram_addr] <= ram_din[7:0];
                2'b01: begin
                    ram_mem[ram_addr]        <= ram_din[15:8];
                    ram_mem[ram_addr + 8'd1] <= ram_din[7:0];
                end
                default: begin
                    ram_mem[ram_addr]        <= ram_din[31:24];
                    ram_mem[ram_addr + 8'd1] <= ram_din[23:16];
                    ram_mem[ram_addr + 8'd2] <= ram_din[15:8];
                    ram_mem[ram_addr + 8'd3] <= ram_din[7:0];
                end
            endcase
        end
        en_run <= ram_enable ? en_run + 1 : 0;
    end

    assign ram_done = ram_enable && (en_run >= done_delay);

    always_comb begin
        case (ram_mas)
            2'b00:   ram_dout = {24'h0, ram_mem[ram_addr]};
            2'b01:   ram_dout = {16'h0, ram_mem[ram_addr], ram_mem[ram_addr + 8'd1]};
            default: ram_dout = {ram_mem[ram_addr], ram_mem[ram_addr + 8'd1],
                                 ram_mem[ram_addr + 8'd2], ram_mem[ram_addr + 8'd3]};
        endcase
    end

    // Reference model: expected memory image, per-port read data and arbitration history.
    typedef struct {
        bit          is_data;
        bit          err;
        logic [31:0] d_rd;
        logic [31:0] if_rd;
        int          lat;
        int          en;
        int          acc_ref;
        bit          chained;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [256];
    logic [31:0] exp_d_rd  = 32'h0;
    logic [31:0] exp_if_rd = 32'h0;
    bit          last_data = 1'b0;

    function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [1:0] mas);
        case (mas)
            2'b00:   return {24'h0, ref_mem[a]};
            2'b01:   return {16'h0, ref_mem[a], ref_mem[a + 8'd1]};
            default: return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_txn(input bit is_data, input bit rw_in, input logic [1:0] mas_in,
                             input logic [7:0] addr, input logic [31:0] wdata,
                             input int acc_ref, input bit chained);
        exp_t       e;
        bit         rw  = is_data ? rw_in : 1'b1;
        logic [1:0] mas = is_data ? mas_in : 2'b10;
        bit         bad;
        int         c;
        last_data = is_data;
        bad = (mas == 2'b11) || (mas == 2'b01 && addr[0]) || (mas == 2'b10 && addr[1:0] != 2'b00);
        e.is_data = is_data;
        e.acc_ref = acc_ref;
        e.chained = chained;
        if (bad) begin
            e.err = 1'b1; e.lat = 1; e.en = 0;
        end else begin
            // Enabled cycle c (ISSUE is 1) completes once c >= WC+1 and done is already high.
            c = (done_delay + 1 > WC + 1) ? done_delay + 1 : WC + 1;
            if (c > TO + 1) begin
                e.err = 1'b1; e.lat = TO + 2; e.en = TO + 1;
            end else begin
                e.err = 1'b0; e.lat = c + 1; e.en = c;
                if (rw) begin
                    if (is_data) exp_d_rd = ref_read(addr, mas);
                    else         exp_if_rd = ref_read(addr, mas);
                end else begin
                    case (mas)
                        2'b00: ref_mem[addr] = wdata[7:0];
                        2'b01: begin
                            ref_mem[addr] = wdata[15:8]; ref_mem[addr + 8'd1] = wdata[7:0];
                        end
                        default: begin
                            ref_mem[addr] = wdata[31:24];        ref_mem[addr + 8'd1] = wdata[23:16];
                            ref_mem[addr + 8'd2] = wdata[15:8];  ref_mem[addr + 8'd3] = wdata[7:0];
                        end
                    endcase
                end
            end
        end
        e.d_rd  = exp_d_rd;
        e.if_rd = exp_if_rd;
        sb.push_back(e);
    endtask

    task automatic single_txn(input bit is_data, input bit rw, input logic [1:0] mas,
                              input logic [7:0] addr, input logic [31:0] wdata, input int dly);
        bit got = 1'b0;
        done_delay = dly;
        if (is_data) begin
            d_rw = rw; d_mas = mas; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        model_txn(is_data, rw, mas, addr, wdata, cyc, 1'b0);
        for (int n = 0; n < TO + 10 && !got; n++) begin
            @(negedge clk);
            got = is_data ? d_ack : if_ack;
            @(posedge clk); #1;
            if (!got) begin
                d_rw = 1'($urandom); d_mas = 2'($urandom); d_addr = 8'($urandom);
                d_wdata = $urandom;  if_addr = 8'($urandom);
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        check(is_data ? "d_ack_seen" : "if_ack_seen", 32'(got), 32'd1);
    endtask

    task automatic rand_ops(output bit rw, output logic [1:0] mas, output logic [7:0] addr,
                            output logic [31:0] wdata);
        rw    = 1'($urandom);
        mas   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        addr  = 8'($urandom);
        wdata = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (mas == 2'b01) addr[0] = 1'b0;
            if (mas == 2'b10) addr[1:0] = 2'b00;
        end
    endtask

    task automatic pair_txn(input int dly);
        bit          rw, gd = 1'b0, gi = 1'b0, ad, ai;
        logic [1:0]  mas;
        logic [7:0]  addr, faddr;
        logic [31:0] wdata;
        bit          first_data;
        rand_ops(rw, mas, addr, wdata);
        faddr = 8'($urandom);
        if ($urandom_range(0, 3) != 0) faddr[1:0] = 2'b00;
        done_delay = dly;
        d_rw = rw; d_mas = mas; d_addr = addr; d_wdata = wdata; if_addr = faddr;
        d_req = 1'b1; if_req = 1'b1;
        first_data = !last_data;
        if (first_data) begin
            model_txn(1'b1, rw, mas, addr, wdata, cyc, 1'b0);
            model_txn(1'b0, 1'b1, 2'b10, faddr, 32'h0, 0, 1'b1);
        end else begin
            model_txn(1'b0, 1'b1, 2'b10, faddr, 32'h0, cyc, 1'b0);
            model_txn(1'b1, rw, mas, addr, wdata, 0, 1'b1);
        end
        for (int n = 0; n < 2 * (TO + 10) && !(gd && gi); n++) begin
            @(negedge clk);
            ad = d_ack; ai = if_ack;
            @(posedge clk); #1;
            if (ad) begin gd = 1'b1; d_req = 1'b0; end
            if (ai) begin gi = 1'b1; if_req = 1'b0; end
        end
        d_req = 1'b0; if_req = 1'b0;
        check("pair_d_ack_seen", 32'(gd), 32'd1);
        check("pair_if_ack_seen", 32'(gi), 32'd1);
    endtask

    task automatic model_reset();
        last_data = 1'b0;
        exp_d_rd  = 32'h0;
        exp_if_rd = 32'h0;
    endtask

    // Monitor: every ack/err cycle pops the oldest expectation and compares it.
    int last_ack = 0;
    int en_cnt   = 0;
    initial begin
        exp_t e;
        int   acc;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                en_cnt = 0;
            end else begin
                if (ram_enable) en_cnt++;
                if (d_ack || if_ack || d_err || if_err) begin
                    check("ack_exclusive", 32'(d_ack & if_ack), 32'd0);
                    check("err_needs_own_ack", 32'((d_err & !d_ack) | (if_err & !if_ack)), 32'd0);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_ack: d_ack=%0b if_ack=%0b but no access outstanding (cycle %0d)",
                                 d_ack, if_ack, cyc);
                    end else begin
                        e   = sb.pop_front();
                        acc = e.chained ? last_ack + 1 : e.acc_ref;
                        check("ack_port_is_data", 32'(d_ack), 32'(e.is_data));
                        check("err", 32'(e.is_data ? d_err : if_err), 32'(e.err));
                        check("d_rdata", d_rdata, e.d_rd);
                        check("if_rdata", if_rdata, e.if_rd);
                        check("latency", 32'(cyc - acc), 32'(e.lat));
                        check("enable_cycles", 32'(en_cnt), 32'(e.en));
                    end
                    last_ack = cyc;
                    en_cnt   = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          rw;
        logic [1:0]  mas;
        logic [7:0]  addr;
        logic [31:0] wdata;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_enable", 32'(ram_enable), 32'd0);
        check("rst_ram_rw", 32'(ram_rw), 32'd1);
        check("rst_ram_mas", 32'(ram_mas), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", ram_din, 32'd0);
        check("rst_ack_err", 32'({d_ack, d_err, if_ack, if_err}), 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        reset_n = 1'b1;

        // Simultaneous requests straight out of reset, then a second simultaneous pair.
        pair_txn(0);
        pair_txn(0);

        // Word write then word read at 0x10.
        single_txn(1'b1, 1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 0);
        single_txn(1'b1, 1'b1, 2'b10, 8'h10, 32'h0, 0);
        check("word_readback", d_rdata, 32'hDEADBEEF);

        // Alignment / illegal-size faults.
        single_txn(1'b1, 1'b1, 2'b10, 8'h12, 32'h0, 0);
        single_txn(1'b1, 1'b1, 2'b11, 8'h10, 32'h0, 0);

        // RAM never answers: timeout error, read data kept.
        single_txn(1'b1, 1'b1, 2'b10, 8'h10, 32'h0, 100);
        check("timeout_rdata_kept", d_rdata, 32'hDEADBEEF);

        // Byte write / byte read / half read around 0x20.
        single_txn(1'b1, 1'b0, 2'b00, 8'h21, 32'h0000005A, 1);
        single_txn(1'b1, 1'b1, 2'b00, 8'h21, 32'h0, 0);
        check("byte_read", d_rdata, 32'h0000005A);
        single_txn(1'b1, 1'b1, 2'b01, 8'h20, 32'h0, 3);
        check("half_read", d_rdata, {16'h0, init_byte(32'h20), 8'h5A});

        // Reset while the access sits in WAIT.
        done_delay = 100;
        d_rw = 1'b1; d_mas = 2'b10; d_addr = 8'h10; d_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0; d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ram_enable", 32'(ram_enable), 32'd0);
        check("midrst_d_ack", 32'(d_ack), 32'd0);
        check("midrst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        single_txn(1'b1, 1'b1, 2'b10, 8'h10, 32'h0, 0);
        pair_txn(1);

        for (int k = 0; k < 40; k++) begin
            rand_ops(rw, mas, addr, wdata);
            if ($urandom_range(0, 3) == 0) begin
                addr = 8'($urandom);
                if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            end
            single_txn($urandom_range(0, 3) != 0, rw, mas, addr, wdata,
                       ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3));
        end
        for (int k = 0; k < 6; k++) pair_txn($urandom_range(0, 3));

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
